// File: rtl/action_sequencer_if.sv
// Command port between the script/decision logic and the action sequencer:
// a {func, target} command offered under a valid/ready handshake.
interface action_sequencer_if #(
  parameter int TGT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_func;
  logic [TGT_W-1:0] cmd_target;

  modport master (output cmd_valid, output cmd_func, output cmd_target, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_func, input cmd_target, output cmd_ready);
endinterface

// File: rtl/action_sequencer.sv
// Queued action driver: buffers {func, target} commands in a FIFO and runs each
// through a move phase (with watchdog) and a timed action strobe.
module action_sequencer #(
  parameter int TGT_W   = 8,
  parameter int DEPTH   = 4,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   abort,
  action_sequencer_if.slave      cmd,
  input  logic                   move_ready,
  output logic [TGT_W-1:0]       target_machine,
  output logic [4:0]             control_data,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int HLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [4:0] MOVE_BITS = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_ACT  = 2'd2
  } state_t;

  state_t           state_r;
  logic [1:0]       func_r;
  logic [TMR_W-1:0] timer_r;
  logic [HLD_W-1:0] hold_r;

  logic [TGT_W+1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic [TGT_W+1:0] head_s;

  function automatic logic [4:0] action_bits(input logic [1:0] func);
    case (func)
      2'd0:    action_bits = 5'b00001;
      2'd1:    action_bits = 5'b00010;
      2'd2:    action_bits = 5'b00100;
      default: action_bits = 5'b01000;
    endcase
  endfunction

  assign full_s        = (count_r == CNT_W'(DEPTH));
  assign cmd.cmd_ready = !full_s;
  // An abort discards any push offered in the same cycle.
  assign push_s        = cmd.cmd_valid && !full_s && !abort;
  assign pop_s         = (state_r == S_IDLE) && en && (count_r != CNT_W'(0)) && !abort;
  assign head_s        = mem_r[rd_ptr_r];
  assign fifo_count    = count_r;

  // FIFO payload storage, written at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd.cmd_func, cmd.cmd_target};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Command FSM; outputs are loaded with the value belonging to the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      func_r         <= 2'd0;
      target_machine <= TGT_W'(0);
      timer_r        <= TMR_W'(0);
      hold_r         <= HLD_W'(0);
      control_data   <= 5'b00000;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
    end else if (abort) begin
      state_r      <= S_IDLE;
      timer_r      <= TMR_W'(0);
      hold_r       <= HLD_W'(0);
      control_data <= 5'b00000;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (!en) begin
      control_data <= 5'b00000;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            func_r         <= head_s[TGT_W+1:TGT_W];
            target_machine <= head_s[TGT_W-1:0];
            timer_r        <= TMR_W'(0);
            hold_r         <= HLD_W'(0);
            busy           <= 1'b1;
            // THROW needs no approach and strobes straight away
            if (head_s[TGT_W+1:TGT_W] == 2'd3) begin
              state_r      <= S_ACT;
              control_data <= action_bits(2'd3);
            end else begin
              state_r      <= S_MOVE;
              control_data <= MOVE_BITS;
            end
          end else begin
            control_data <= 5'b00000;
            busy         <= 1'b0;
          end
        end
        S_MOVE: begin
          if (move_ready) begin
            state_r      <= S_ACT;
            timer_r      <= TMR_W'(0);
            control_data <= action_bits(func_r);
          end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
            state_r      <= S_IDLE;
            timer_r      <= TMR_W'(0);
            control_data <= 5'b00000;
            busy         <= 1'b0;
            timeout_err  <= 1'b1;
          end else begin
            timer_r      <= timer_r + TMR_W'(1);
            control_data <= MOVE_BITS;
          end
        end
        S_ACT: begin
          if (hold_r == HLD_W'(HOLD - 1)) begin
            state_r      <= S_IDLE;
            hold_r       <= HLD_W'(0);
            control_data <= 5'b00000;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else begin
            hold_r       <= hold_r + HLD_W'(1);
            control_data <= action_bits(func_r);
          end
        end
        default: begin
          state_r      <= S_IDLE;
          control_data <= 5'b00000;
          busy         <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_action_sequencer.sv
// Self-checking bench for action_sequencer: directed test-plan scenarios plus
// randomized traffic, all checked against a queue-based behavioural model.
module tb_action_sequencer;
  localparam int TGT_W   = 8;
  localparam int DEPTH   = 4;
  localparam int HOLD    = 2;
  localparam int TIMEOUT = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             abort = 1'b0;
  logic             move_ready = 1'b0;
  logic [TGT_W-1:0] target_machine;
  logic [4:0]       control_data;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [2:0]       fifo_count;

  action_sequencer_if #(.TGT_W(TGT_W)) bus ();

  action_sequencer #(.TGT_W(TGT_W), .DEPTH(DEPTH), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .abort(abort), .cmd(bus),
    .move_ready(move_ready), .target_machine(target_machine),
    .control_data(control_data), .busy(busy), .done(done),
    .timeout_err(timeout_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Behavioural model: a pending queue plus a description of the active command
  typedef struct { logic [1:0] func; logic [TGT_W-1:0] tgt; } cmd_t;
  cmd_t q[$];
  cmd_t cur;
  bit   active = 1'b0;
  bit   moving = 1'b0;
  int   waited = 0;
  int   shown = 0;
  bit   acc;
  logic [4:0]       exp_ctrl = 5'd0;
  logic [TGT_W-1:0] exp_tgt = '0;
  logic             exp_done = 1'b0;
  logic             exp_to = 1'b0;

  always @(posedge clk) begin
    acc = bus.cmd_valid && (q.size() < DEPTH) && !abort;
    if (rst) begin
      q.delete(); active = 0; exp_ctrl = 5'd0; exp_tgt = '0; exp_done = 0; exp_to = 0;
    end else if (abort) begin
      q.delete(); active = 0; exp_ctrl = 5'd0; exp_done = 0; exp_to = 0;
    end else begin
      exp_done = 0; exp_to = 0;
      if (en) begin
        if (!active) begin
          if (q.size() > 0) begin
            cur = q.pop_front();
            active = 1; waited = 0; shown = 0;
            moving = (cur.func != 2'd3);
            exp_tgt = cur.tgt;
          end
        end else if (moving) begin
          if (move_ready) moving = 0;
          else begin
            waited++;
            if (waited == TIMEOUT) begin active = 0; exp_to = 1; end
          end
        end else begin
          shown++;
          if (shown == HOLD) begin active = 0; exp_done = 1; end
        end
        exp_ctrl = !active ? 5'd0 : (moving ? 5'b10000 : (5'b00001 << cur.func));
      end else begin
        exp_ctrl = 5'd0;
      end
      if (acc) q.push_back('{bus.cmd_func, bus.cmd_target});
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("control_data", 32'(control_data), 32'(exp_ctrl));
      chk("target_machine", 32'(target_machine), 32'(exp_tgt));
      chk("done", 32'(done), 32'(exp_done));
      chk("timeout_err", 32'(timeout_err), 32'(exp_to));
      chk("busy", 32'(busy), 32'(active));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(q.size() < DEPTH));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] f, input logic [TGT_W-1:0] t);
    bus.cmd_valid = 1'b1; bus.cmd_func = f; bus.cmd_target = t;
  endtask

  int n;
  int ndone;
  logic [TGT_W-1:0] seen [4];

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_func = 2'd0; bus.cmd_target = '0;
    tick(); chk_on = 1'b1; tick();
    rst = 1'b0;
    chk("reset ctrl", 32'(control_data), 32'h0);
    chk("reset ready", 32'(bus.cmd_ready), 32'h1);
    chk("reset count", 32'(fifo_count), 32'h0);
    en = 1'b1;

    // GET to target 5, move_ready seen on the third MOVE edge
    offer(2'd0, 8'h05); tick(); bus.cmd_valid = 1'b0;
    tick(); chk("get move1", 32'(control_data), 32'h10); chk("get tgt", 32'(target_machine), 32'h05);
    tick(); chk("get move2", 32'(control_data), 32'h10);
    tick(); chk("get move3", 32'(control_data), 32'h10); move_ready = 1'b1;
    tick(); chk("get act1", 32'(control_data), 32'h01); move_ready = 1'b0;
    tick(); chk("get act2", 32'(control_data), 32'h01);
    tick(); chk("get done", 32'(done), 32'h1); chk("get idle", 32'(control_data), 32'h0);
    tick();

    // THROW goes straight to the strobe
    offer(2'd3, 8'h22); tick(); bus.cmd_valid = 1'b0;
    tick(); chk("throw act1", 32'(control_data), 32'h08);
    tick(); chk("throw act2", 32'(control_data), 32'h08);
    tick(); chk("throw done", 32'(done), 32'h1);
    tick();

    // Reset while in MOVE
    offer(2'd1, 8'h77); tick(); bus.cmd_valid = 1'b0; tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst ctrl", 32'(control_data), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst count", 32'(fifo_count), 32'h0);
    chk("rst tgt", 32'(target_machine), 32'h0);

    // Queue full with en low, then drain in order
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(2'(i), 8'h10 + 8'(i)); tick();
      if (i == 3) begin
        chk("full ready", 32'(bus.cmd_ready), 32'h0);
        chk("full count", 32'(fifo_count), 32'h4);
      end
    end
    bus.cmd_valid = 1'b0;
    chk("full fifth dropped", 32'(fifo_count), 32'h4);
    en = 1'b1; move_ready = 1'b1; ndone = 0;
    for (int i = 0; i < 100 && ndone < 4; i++) begin
      tick();
      if (done === 1'b1) begin seen[ndone] = target_machine; ndone++; end
    end
    move_ready = 1'b0;
    chk("drain dones", 32'(ndone), 32'h4);
    for (int i = 0; i < 4; i++) chk("drain order", 32'(seen[i]), 32'h10 + 32'(i));
    tick();

    // Watchdog: two commands with move_ready held low
    offer(2'd0, 8'h30); tick(); offer(2'd1, 8'h31); tick(); bus.cmd_valid = 1'b0;
    n = 0;
    while (control_data === 5'b10000 && n < 50) begin n++; tick(); end
    chk("timeout move cycles", 32'(n), 32'd10);
    chk("timeout pulse", 32'(timeout_err), 32'h1);
    tick();
    chk("next after timeout", 32'(control_data), 32'h10);
    chk("next tgt", 32'(target_machine), 32'h31);
    repeat (12) tick();

    // Freeze during ACT
    move_ready = 1'b1; offer(2'd0, 8'h40); tick(); bus.cmd_valid = 1'b0;
    tick(); tick(); chk("frz act", 32'(control_data), 32'h01);
    en = 1'b0; move_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("frz zero", 32'(control_data), 32'h0); chk("frz nodone", 32'(done), 32'h0);
    end
    en = 1'b1;
    tick(); chk("frz resume", 32'(control_data), 32'h01);
    tick(); chk("frz done", 32'(done), 32'h1);
    tick();

    // Abort with an active MOVE and two entries queued
    for (int i = 0; i < 3; i++) begin offer(2'd2, 8'h50 + 8'(i)); tick(); end
    chk("abort pre count", 32'(fifo_count), 32'h2);
    chk("abort pre busy", 32'(busy), 32'h1);
    abort = 1'b1; offer(2'd0, 8'h66); tick(); abort = 1'b0; bus.cmd_valid = 1'b0;
    chk("abort count", 32'(fifo_count), 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort tgt kept", 32'(target_machine), 32'h50);
    repeat (5) begin tick(); chk("abort nodone", 32'(done), 32'h0); end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.cmd_valid  = ($urandom_range(0, 2) == 0);
      bus.cmd_func   = 2'($urandom_range(0, 3));
      bus.cmd_target = 8'($urandom);
      en         = ($urandom_range(0, 7) != 0);
      move_ready = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 96) == 0);
      rst        = ($urandom_range(0, 498) == 0);
      tick();
    end
    bus.cmd_valid = 1'b0; abort = 1'b0; rst = 1'b0; en = 1'b1; move_ready = 1'b1;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/action_sequencer.md
# action_sequencer

Queued successor to the single-shot action driver. Accepts {func, target} commands through a valid/ready port into a DEPTH-entry FIFO and executes them one at a time. Each GET/PUT/INTERACT moves to the target until `move_ready`, holds the action strobe for HOLD cycles and signals completion. THROW fires immediately. A move-phase watchdog reports a timeout and drops the command. It sits between the script/decision logic and the game-interface transmitter that consumes `control_data` and `target_machine`.

## Interface
- TGT_W, 8: width of the target machine id.
- DEPTH, 4: command FIFO depth; power of two, ≥2.
- HOLD, 2: cycles the action strobe is held; ≥1.
- TIMEOUT, 255: maximum MOVE-state cycles before abort; ≥2.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  execution enable; low freezes the FSM and timers and forces `control_data`=0.
- abort  in  1  returns the FSM to IDLE and empties the FIFO on the next edge.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  = FIFO not full (combinational from count).
- cmd_func  in  2  command function: 0 GET, 1 PUT, 2 INTERACT, 3 THROW.
- cmd_target  in  TGT_W  target machine id.
- move_ready  in  1  player has reached the target.
- target_machine  out  TGT_W  latched target of the active command.
- control_data  out  5  {move, throw, interact, put, get}, registered, one-hot or zero.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- timeout_err  out  1  one-cycle pulse when a command is dropped on timeout.
- fifo_count  out  $clog2(DEPTH)+1  entries queued.

## Operation
- **Reset values:** all outputs 0, FIFO empty, state IDLE. `cmd_ready` is 1 after reset.
- **FIFO push:** occurs when cmd_valid & cmd_ready. A push while full is impossible, since ready=0.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- **IDLE:** `control_data`=0. If en & !empty & !abort, pop the head and latch func and target. Next state is ACT for THROW, MOVE otherwise.
- **MOVE:** `control_data`=10000, timer starts at 0 on entry.
  - If move_ready is high, go to ACT and clear the timer.
  - Otherwise, if timer==TIMEOUT-1, go to IDLE and pulse `timeout_err`.
  - Otherwise, increment the timer.
  - When move_ready and timeout coincide, move_ready wins.
- **ACT:** `control_data` = the action bit (GET 00001, PUT 00010, INTERACT 00100, THROW 01000) for exactly HOLD enabled cycles. Then go to IDLE and pulse `done`.
- **en low:** state, timer and hold counter all freeze, and `control_data`=0. The FIFO still accepts pushes. When en returns high, the FSM resumes where it stopped.
- **abort:**
  - Overrides everything except rst.
  - No done or timeout pulse is generated.
  - A push in the same cycle as abort is discarded.
  - `target_machine` keeps its last value.
- **rst mid-command:** everything returns to reset values on that edge.

## Timing
- A command accepted at edge E0 is popped at edge E1 (IDLE). From E1 the FSM is in MOVE with `control_data`=10000, or in ACT for THROW.
- move_ready sampled high at edge Ek: the action bit is present from Ek for HOLD cycles, then `control_data`=0 with `done`=1 for one cycle.
- Back-to-back commands: the next pop happens on the edge that enters IDLE+1. Between commands there is ≥1 cycle of `control_data`=0.
- MOVE lasts at most TIMEOUT enabled cycles. `timeout_err` is asserted in the first IDLE cycle after that.
- `target_machine` updates on the pop edge and is stable for the whole command.

## Test plan
- **Reset:** assert rst for 2 cycles mid-MOVE → all outputs 0, cmd_ready=1, fifo_count=0.
- **GET to target 8'h05, HOLD=2:** move_ready rises 3 cycles after MOVE entry → control_data 10000 ×3, 00001 ×2, then done=1 and control_data=0. target_machine=5 throughout.
- **THROW:** push func=3 → control_data=01000 for 2 cycles on the cycle after the pop, no MOVE phase, then done.
- **Queue full:** push 5 commands back-to-back with DEPTH=4 and en=0 → cmd_ready=0 after the 4th and fifo_count=4. Raise en → 4 commands execute in FIFO order, each with its own done.
- **Timeout:** TIMEOUT=10, move_ready held low → exactly 10 cycles of 10000, then timeout_err=1, and the next queued command starts.
- **Freeze/abort:** drop en for 3 cycles during ACT → control_data=0 and the hold count resumes afterwards. Then assert abort with 2 entries queued → IDLE, fifo_count=0, no done.
